uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART. It synchronises the serial line, generates 16x oversample ticks, validates the start bit and centre-samples the data, parity and stop bits. It delivers each completed byte with its error flags through a valid/ready output register. It replaces the loose start/shift/parity/stop strobes that currently sit between the UART receive sub-blocks with one timed controller.

Parameters:
CLK_DIV, 8, system clocks per oversample tick (≥1)
OVS, 16, oversample ticks per bit (even, ≥4)
PARITY_EN, 1, 1 = a parity bit follows the data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
rx_in  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte, LSB received first
rx_valid  output  1  rx_data and flags hold an undelivered frame
rx_ready  input  1  consumer accepts the frame when rx_valid && rx_ready
parity_err  output  1  parity mismatch for the frame in rx_data
stop_err  output  1  stop bit sampled low for the frame in rx_data
overrun  output  1  sticky: a frame was dropped because the output was full
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: clk edge with reset==0 forces all outputs to 0 (rx_data=8'h00), state to IDLE, both counters to 0, and both synchroniser flops plus the edge-detect register to 1. Reset mid-frame abandons the frame with no output.
- Sync: rx_in passes through a 2-flop synchroniser to give rx_s. The previous rx_s value is kept for falling-edge detection.
- Tick: div_cnt counts 0..CLK_DIV-1 and wraps; tick=1 on the wrap cycle. div_cnt clears on a start edge. CLK_DIV=1 gives tick every cycle.
- States: IDLE, START, DATA, PARITY, STOP. ovs_cnt counts ticks within the current bit.
- IDLE: on a rx_s falling edge (prev 1, now 0), clear div_cnt and ovs_cnt and go to START. A level-low line with no edge (break, or after a stop error) never starts a frame.
- START: at the tick where ovs_cnt==OVS/2-1, sample rx_s.
  - rx_s==0: clear ovs_cnt, clear bit_idx, go to DATA.
  - rx_s==1: false start, go to IDLE with no flags.
- DATA: at the tick where ovs_cnt==OVS-1, shift rx_s into shreg[7] (right shift, LSB first), clear ovs_cnt, increment bit_idx. After bit_idx 7, go to PARITY if PARITY_EN, else STOP.
- PARITY: at the OVS-1 tick, latch perr = (^shreg ^ rx_s) != PARITY_ODD, then go to STOP.
- STOP: at the OVS-1 tick, serr = ~rx_s. Complete the frame and go to IDLE on the same edge.
- Frame completion, evaluated on the completion edge:
  - If output is empty, or full with rx_ready==1 that cycle: load rx_data=shreg, parity_err=perr (0 if !PARITY_EN), stop_err=serr; rx_valid=1 next cycle.
  - Otherwise: the new frame is discarded, the existing output is unchanged, overrun=1.
- Output handshake: on an rx_valid && rx_ready cycle with no simultaneous load, rx_valid clears. rx_data, parity_err and stop_err hold their values until the next load.
- overrun stays set until the next frame is loaded successfully, then clears on that load edge.
- Latency: rx_valid rises one clk after the tick that samples the stop-bit centre.
- Frames with stop_err are still delivered.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit)
  - UART_DATA_BITS=8
  - default OVS
- One natural sub-module: uart_baud_tick (div_cnt, tick, synchronous clear input), reusable by the transmit side.

Test Plan:
- CLK_DIV=1, OVS=16, even parity; send 8'hA5 with parity 0 and stop 1 at 16 clocks/bit, rx_ready=1 → one rx_valid pulse, rx_data=8'hA5, parity_err=0, stop_err=0, overrun=0; busy low after stop.
- Same config; 4-clock low glitch on idle rx_in → state returns to IDLE at the mid-start sample, no rx_valid, all flags 0.
- Send 8'h01 with parity bit 0 (wrong for even) → rx_data=8'h01, parity_err=1.
  - Repeat with PARITY_ODD=1 → parity_err=0.
- Send 8'h3C with stop bit 0, then hold the line low 40 clocks, then high → rx_data=8'h3C, stop_err=1, no second frame during the low hold.
- rx_ready=0; send 8'h3C then 8'hC3 back-to-back → rx_data stays 8'h3C, overrun=1. Raise rx_ready for one cycle → rx_valid clears; next frame 8'h55 loads and clears overrun.
- Assert reset=0 for one clock mid-DATA of a frame → all outputs 0, IDLE.
  - The rest of that frame's bits must not produce rx_valid unless a genuine falling edge begins a new start bit.
  - A following clean 8'h7E frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive definitions: FSM state encoding, frame width, default oversample.
// Also holds the parity-check helper used by the receive sequencer.
package uart_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_DEFAULT_OVS = 16;

    // Data bits XOR parity bit must equal the selected polarity (0 even, 1 odd).
    function automatic logic parity_mismatch(input logic [UART_DATA_BITS-1:0] data,
                                             input logic par_bit,
                                             input logic odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, restartable by clr_i.
// Tick is combinational from the counter; no backpressure.
module uart_baud_tick #(
    parameter int CLK_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (clr_i || (div_cnt_q == DIV_LAST)) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // With CLK_DIV=1 the counter sits at 0 == DIV_LAST, so tick is held high.
    assign tick_o = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: sync, start validation, centre sampling, byte delivery with flags.
// rx_valid rises one clk after the stop-centre tick; a frame completing into a full output is dropped and flags overrun.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int OVS        = UART_DEFAULT_OVS,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      parity_err,
    output logic                      stop_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int OW = $clog2(OVS);
    localparam logic [OW-1:0] OVS_MID  = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    logic                      sync1_q;
    logic                      rx_s_q;
    logic                      rx_prev_q;
    rx_state_e                 state_q;
    logic [OW-1:0]             ovs_cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shreg_q;
    logic                      perr_q;
    logic [UART_DATA_BITS-1:0] rx_data_q;
    logic                      rx_valid_q;
    logic                      parity_err_q;
    logic                      stop_err_q;
    logic                      overrun_q;

    logic tick;
    logic start_edge;
    logic bit_end;
    logic frame_done;
    logic load;

    assign start_edge = (state_q == ST_IDLE) && rx_prev_q && !rx_s_q;
    assign bit_end    = tick && (ovs_cnt_q == OVS_LAST);
    assign frame_done = (state_q == ST_STOP) && bit_end;
    assign load       = frame_done && (!rx_valid_q || rx_ready);

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (start_edge),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= ST_IDLE;
            ovs_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            stop_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q   <= rx_in;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;

            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            // A load on the same edge as a handshake overrides the clear above.
            if (load) begin
                rx_data_q    <= shreg_q;
                parity_err_q <= (PARITY_EN != 0) ? perr_q : 1'b0;
                stop_err_q   <= !rx_s_q;
                rx_valid_q   <= 1'b1;
                overrun_q    <= 1'b0;
            end else if (frame_done) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        ovs_cnt_q <= '0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (ovs_cnt_q == OVS_MID) begin
                            ovs_cnt_q <= '0;
                            if (!rx_s_q) begin
                                bit_idx_q <= '0;
                                perr_q    <= 1'b0;
                                state_q   <= ST_DATA;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            ovs_cnt_q <= ovs_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg_q   <= {rx_s_q, shreg_q[UART_DATA_BITS-1:1]};
                        ovs_cnt_q <= '0;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end else if (tick) begin
                        ovs_cnt_q <= ovs_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        perr_q    <= parity_mismatch(shreg_q, rx_s_q, PAR_ODD);
                        ovs_cnt_q <= '0;
                        state_q   <= ST_STOP;
                    end else if (tick) begin
                        ovs_cnt_q <= ovs_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        ovs_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else if (tick) begin
                        ovs_cnt_q <= ovs_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign stop_err   = stop_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at CLK_DIV=1, OVS=16 (16 clocks per bit), even and odd parity instances.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic       rx_ready;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       stop_err;
    logic       overrun;
    logic       busy;

    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_parity_err;
    logic       o_stop_err;
    logic       o_overrun;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    int         hs_cnt = 0;
    logic [7:0] hs_data = 8'h00;

    uart_rx_ctrl #(
        .CLK_DIV    (1),
        .OVS        (16),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .stop_err   (stop_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    uart_rx_ctrl #(
        .CLK_DIV    (1),
        .OVS        (16),
        .PARITY_EN  (1),
        .PARITY_ODD (1)
    ) dut_odd (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_data    (o_rx_data),
        .rx_valid   (o_rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (o_parity_err),
        .stop_err   (o_stop_err),
        .overrun    (o_overrun),
        .busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && rx_valid && rx_ready) begin
            hs_cnt  <= hs_cnt + 1;
            hs_data <= rx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hs0;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",   32'(rx_data), 32'h00);
        chk("rst_valid",  32'(rx_valid), 0);
        chk("rst_flags",  32'({parity_err, stop_err, overrun}), 0);
        chk("rst_busy",   32'(busy), 0);
        reset = 1'b1;
        idle(5);

        // Clean frame, even parity correct
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        chk("a5_hs_cnt", 32'(hs_cnt), 1);
        chk("a5_data",   32'(hs_data), 32'hA5);
        chk("a5_flags",  32'({parity_err, stop_err, overrun}), 0);
        chk("a5_busy",   32'(busy), 0);
        chk("a5_valid",  32'(rx_valid), 0);

        // Short glitch is rejected at the mid-start sample
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_mid", 32'(busy), 1);
        idle(20);
        chk("glitch_busy_end", 32'(busy), 0);
        chk("glitch_no_frame", 32'(hs_cnt), 1);
        chk("glitch_flags",    32'({parity_err, stop_err, overrun}), 0);

        // Parity bit 0 for 8'h01: wrong for even, right for odd
        send_frame(8'h01, 1'b0, 1'b1);
        idle(20);
        chk("p01_hs_cnt",   32'(hs_cnt), 2);
        chk("p01_data",     32'(rx_data), 32'h01);
        chk("p01_perr_even", 32'(parity_err), 1);
        chk("p01_odd_data", 32'(o_rx_data), 32'h01);
        chk("p01_perr_odd", 32'(o_parity_err), 0);

        // Stop bit low, line held low: delivered with stop_err, no second frame
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (40) @(negedge clk);
        chk("brk_busy_low", 32'(busy), 0);
        idle(40);
        chk("brk_hs_cnt", 32'(hs_cnt), 3);
        chk("brk_data",   32'(rx_data), 32'h3C);
        chk("brk_serr",   32'(stop_err), 1);
        chk("brk_perr",   32'(parity_err), 0);

        // Overrun: two frames with no consumer
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(20);
        chk("ovr_valid", 32'(rx_valid), 1);
        chk("ovr_data",  32'(rx_data), 32'h3C);
        chk("ovr_flag",  32'(overrun), 1);
        chk("ovr_serr",  32'(stop_err), 0);
        hs0 = hs_cnt;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("ovr_hs_cnt",   32'(hs_cnt), 32'(hs0 + 1));
        chk("ovr_hs_data",  32'(hs_data), 32'h3C);
        chk("ovr_valid_clr", 32'(rx_valid), 0);
        chk("ovr_sticky",   32'(overrun), 1);
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        chk("f55_data",    32'(hs_data), 32'h55);
        chk("f55_ovr_clr", 32'(overrun), 0);

        // Reset mid-DATA of 8'hFE; remaining line has no falling edge
        hs0 = hs_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx_in = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst_data",  32'(rx_data), 32'h00);
        chk("mrst_valid", 32'(rx_valid), 0);
        chk("mrst_flags", 32'({parity_err, stop_err, overrun}), 0);
        chk("mrst_busy",  32'(busy), 0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        idle(40);
        chk("mrst_no_frame", 32'(hs_cnt), 32'(hs0));
        chk("mrst_idle",     32'(busy), 0);

        send_frame(8'h7E, 1'b0, 1'b1);
        idle(20);
        chk("f7e_hs_cnt", 32'(hs_cnt), 32'(hs0 + 1));
        chk("f7e_data",   32'(hs_data), 32'h7E);
        chk("f7e_flags",  32'({parity_err, stop_err, overrun}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
